// File: rtl/MD_pkg.sv
// -----------------------------------------------------------------------------
// MD_pkg
//   Shared cell-level constants and the arbiter state type.
//   NUM_PES_PER_CELL : number of PEs sharing one cell port
//   PE_IDX_WIDTH     : width of a PE index
//   arb_state_t      : burst arbiter FSM state (idle / grant held)
// -----------------------------------------------------------------------------
package MD_pkg;

  localparam int NUM_PES_PER_CELL = 8;
  localparam int PE_IDX_WIDTH     = $clog2(NUM_PES_PER_CELL);

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_priority_picker.sv
// -----------------------------------------------------------------------------
// rr_priority_picker
//   Combinational rotating-priority picker: returns the first set request
//   found searching upward from i_start, wrapping modulo NUM_REQ.
//   i_request : request vector
//   i_start   : index searched first
//   o_onehot  : one-hot winner (zero when nothing requests)
//   o_idx     : winner index (zero when nothing requests)
//   o_valid   : at least one request set
// -----------------------------------------------------------------------------
module rr_priority_picker #(
  parameter int NUM_REQ   = 8,
  parameter int IDX_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]   i_request,
  input  logic [IDX_WIDTH-1:0] i_start,
  output logic [NUM_REQ-1:0]   o_onehot,
  output logic [IDX_WIDTH-1:0] o_idx,
  output logic                 o_valid
);

  int                   w_cand_int;
  logic [IDX_WIDTH-1:0] w_cand;

  always_comb begin
    o_onehot   = '0;
    o_idx      = '0;
    o_valid    = 1'b0;
    w_cand_int = 0;
    w_cand     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // Candidate index (i_start + k) mod NUM_REQ without a divider.
      w_cand_int = int'(i_start) + k;
      if (w_cand_int >= NUM_REQ) w_cand_int = w_cand_int - NUM_REQ;
      w_cand = IDX_WIDTH'(w_cand_int);
      if (!o_valid && i_request[w_cand]) begin
        o_valid          = 1'b1;
        o_idx            = w_cand;
        o_onehot[w_cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pe_wrr_burst_arbiter.sv
// -----------------------------------------------------------------------------
// pe_wrr_burst_arbiter
//   Weighted round-robin arbiter with burst locking between the PEs of a cell
//   and one shared downstream port. A winner keeps the grant for up to
//   weight[i] accepted beats, released early on i_last or a dropped request.
//   clk, rst       : clock, synchronous active-high reset
//   i_arbiter_en   : allows new grants (never preempts a running burst)
//   i_request      : per-requester request
//   i_last         : per-requester last-beat flag (only looked at on a transfer)
//   i_weight       : flat per-requester burst weights, requester i at [i*WW +: WW]
//   i_ready        : downstream accepts the granted beat
//   o_grant        : registered one-hot grant
//   o_grant_valid  : a grant is active
//   o_grant_idx    : index of the granted requester
// -----------------------------------------------------------------------------
module pe_wrr_burst_arbiter
  import MD_pkg::*;
#(
  parameter int NUM_REQ      = NUM_PES_PER_CELL,
  parameter int IDX_WIDTH    = $clog2(NUM_REQ),
  parameter int WEIGHT_WIDTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_arbiter_en,
  input  logic [NUM_REQ-1:0]              i_request,
  input  logic [NUM_REQ-1:0]              i_last,
  input  logic [NUM_REQ*WEIGHT_WIDTH-1:0] i_weight,
  input  logic                            i_ready,
  output logic [NUM_REQ-1:0]              o_grant,
  output logic                            o_grant_valid,
  output logic [IDX_WIDTH-1:0]            o_grant_idx
);

  // Zero weight would never release on credit, so it behaves as one beat.
  function automatic logic [WEIGHT_WIDTH-1:0] eff_weight(input logic [WEIGHT_WIDTH-1:0] w);
    return (w == '0) ? WEIGHT_WIDTH'(1) : w;
  endfunction

  function automatic logic [IDX_WIDTH-1:0] next_idx(input logic [IDX_WIDTH-1:0] i);
    return (i == IDX_WIDTH'(NUM_REQ - 1)) ? '0 : i + 1'b1;
  endfunction

  arb_state_t                r_state, w_state_nxt;
  logic [IDX_WIDTH-1:0]      r_ptr, w_ptr_nxt;
  logic [WEIGHT_WIDTH-1:0]   r_credit, w_credit_nxt;
  logic [NUM_REQ-1:0]        r_grant, w_grant_nxt;
  logic [IDX_WIDTH-1:0]      r_grant_idx, w_grant_idx_nxt;

  logic                      w_granted;
  logic                      w_req_g;
  logic                      w_xfer;
  logic                      w_release;
  logic                      w_new_grant;
  logic [IDX_WIDTH-1:0]      w_pick_start;
  logic [NUM_REQ-1:0]        w_pick_onehot;
  logic [IDX_WIDTH-1:0]      w_pick_idx;
  logic                      w_pick_valid;
  logic [WEIGHT_WIDTH-1:0]   w_pick_weight;

  assign w_granted = (r_state == ARB_GRANT);
  assign w_req_g   = i_request[r_grant_idx];
  assign w_xfer    = w_granted && w_req_g && i_ready;
  // Credit==1 and i_last on the same beat collapse into one release.
  assign w_release = w_granted &&
                     (!w_req_g || (w_xfer && ((r_credit == WEIGHT_WIDTH'(1)) || i_last[r_grant_idx])));

  // On release the search starts just past the current owner, so the owner
  // only wins again when it is the sole requester.
  assign w_pick_start = w_granted ? next_idx(r_grant_idx) : r_ptr;

  rr_priority_picker #(
    .NUM_REQ   (NUM_REQ),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_picker (
    .i_request (i_request),
    .i_start   (w_pick_start),
    .o_onehot  (w_pick_onehot),
    .o_idx     (w_pick_idx),
    .o_valid   (w_pick_valid)
  );

  assign w_pick_weight = i_weight[w_pick_idx*WEIGHT_WIDTH +: WEIGHT_WIDTH];
  assign w_new_grant   = i_arbiter_en && w_pick_valid && (!w_granted || w_release);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ARB_IDLE;
      r_ptr       <= '0;
      r_credit    <= '0;
      r_grant     <= '0;
      r_grant_idx <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_credit    <= w_credit_nxt;
      r_grant     <= w_grant_nxt;
      r_grant_idx <= w_grant_idx_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ARB_IDLE:  if (w_new_grant) w_state_nxt = ARB_GRANT;
      ARB_GRANT: if (w_release)   w_state_nxt = w_new_grant ? ARB_GRANT : ARB_IDLE;
      default:   w_state_nxt = ARB_IDLE;
    endcase
  end

  // Grant, credit and pointer updates
  always_comb begin
    w_ptr_nxt       = r_ptr;
    w_credit_nxt    = r_credit;
    w_grant_nxt     = r_grant;
    w_grant_idx_nxt = r_grant_idx;
    if (w_release) w_ptr_nxt = next_idx(r_grant_idx);
    if (w_new_grant) begin
      w_grant_nxt     = w_pick_onehot;
      w_grant_idx_nxt = w_pick_idx;
      w_credit_nxt    = eff_weight(w_pick_weight);
    end else if (w_release) begin
      w_grant_nxt     = '0;
      w_grant_idx_nxt = '0;
      w_credit_nxt    = '0;
    end else if (w_xfer) begin
      // Not releasing here means credit > 1, so this cannot underflow.
      w_credit_nxt = r_credit - 1'b1;
    end
  end

  assign o_grant       = r_grant;
  assign o_grant_valid = |r_grant;
  assign o_grant_idx   = r_grant_idx;

endmodule

// File: tb/tb_pe_wrr_burst_arbiter.sv
// -----------------------------------------------------------------------------
// tb_pe_wrr_burst_arbiter
//   Directed scenarios followed by randomized traffic, all checked each cycle
//   against a behavioural model of the weighted burst arbiter.
// -----------------------------------------------------------------------------
module tb_pe_wrr_burst_arbiter;
  localparam int N  = 8;
  localparam int WW = 4;
  localparam int IW = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic [N-1:0]    req;
  logic [N-1:0]    last;
  logic [N*WW-1:0] weight;
  logic            ready;
  logic [N-1:0]    o_grant;
  logic            o_grant_valid;
  logic [IW-1:0]   o_grant_idx;

  int n_vec = 0;
  int n_err = 0;

  // Model state: granted requester (-1 = none), rotation pointer, beats left.
  int m_g      = -1;
  int m_ptr    = 0;
  int m_credit = 0;

  always #5 clk = ~clk;

  pe_wrr_burst_arbiter #(
    .NUM_REQ      (N),
    .IDX_WIDTH    (IW),
    .WEIGHT_WIDTH (WW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_arbiter_en  (en),
    .i_request     (req),
    .i_last        (last),
    .i_weight      (weight),
    .i_ready       (ready),
    .o_grant       (o_grant),
    .o_grant_valid (o_grant_valid),
    .o_grant_idx   (o_grant_idx)
  );

  function automatic int wt(int i);
    int w;
    w = int'(weight[i*WW +: WW]);
    return (w == 0) ? 1 : w;
  endfunction

  function automatic int pick(int start);
    for (int k = 0; k < N; k++) begin
      if (req[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  task automatic model_update();
    bit xfer;
    bit rel;
    if (rst) begin
      m_g = -1; m_ptr = 0; m_credit = 0;
    end else if (m_g < 0) begin
      if (en && req != 0) begin
        m_g = pick(m_ptr);
        m_credit = wt(m_g);
      end
    end else begin
      xfer = req[m_g] && ready;
      rel  = !req[m_g] || (xfer && (m_credit == 1 || last[m_g]));
      if (rel) begin
        m_ptr = (m_g + 1) % N;
        if (en && req != 0) begin
          m_g = pick(m_ptr);
          m_credit = wt(m_g);
        end else begin
          m_g = -1;
          m_credit = 0;
        end
      end else if (xfer) begin
        m_credit = m_credit - 1;
      end
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    logic [31:0] exp_grant;
    exp_grant = (m_g < 0) ? 32'd0 : (32'd1 << m_g);
    chk("model_grant", {24'd0, o_grant}, exp_grant);
    chk("model_valid", {31'd0, o_grant_valid}, (m_g >= 0) ? 32'd1 : 32'd0);
    if (m_g >= 0) chk("model_idx", {29'd0, o_grant_idx}, m_g);
  endtask

  // Inputs are already applied; advance one clock and compare just after the edge.
  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    check_model();
  endtask

  int exp3 [5] = '{2, 2, 2, 3, 2};
  int exp4 [4] = '{1, 1, 1, 0};
  logic rdy4 [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    rst = 1'b1; en = 1'b0; req = '0; last = '0; weight = '0; ready = 1'b0;

    // T1: reset and enable gating
    step(); step();
    chk("t1_rst_grant", {24'd0, o_grant}, 32'd0);
    chk("t1_rst_valid", {31'd0, o_grant_valid}, 32'd0);
    chk("t1_rst_idx", {29'd0, o_grant_idx}, 32'd0);
    rst = 1'b0; req = 8'hFF;
    repeat (5) begin
      step();
      chk("t1_en_off", {24'd0, o_grant}, 32'd0);
    end

    // T2: fair rotation with unit weights
    weight = {N{4'h1}}; en = 1'b1; ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t2_rot_idx", {29'd0, o_grant_idx}, i % N);
      chk("t2_rot_valid", {31'd0, o_grant_valid}, 32'd1);
    end

    // T3: weighted burst
    rst = 1'b1; step(); rst = 1'b0;
    weight = 32'h0000_1300; req = 8'h0C;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t3_burst_idx", {29'd0, o_grant_idx}, exp3[i]);
    end

    // T4: backpressure holds credit and grant
    rst = 1'b1; step(); rst = 1'b0;
    weight = 32'h0000_0002; req = 8'h01; ready = 1'b1;
    step();
    chk("t4_load_valid", {31'd0, o_grant_valid}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      ready = rdy4[i];
      if (i == 3) en = 1'b0;
      step();
      chk("t4_bp_valid", {31'd0, o_grant_valid}, exp4[i]);
    end
    en = 1'b1; ready = 1'b1;

    // T5a: early release on i_last, pointer moves past the owner
    rst = 1'b1; step(); rst = 1'b0;
    weight = 32'h0040_0000; req = 8'h20; last = 8'h00;
    step();
    chk("t5_last_first", {29'd0, o_grant_idx}, 32'd5);
    step();
    req = 8'hFF; last = 8'h20;
    step();
    chk("t5_last_next", {29'd0, o_grant_idx}, 32'd6);
    last = 8'h00;

    // T5b: early release on dropped request, newcomer eligible same cycle
    rst = 1'b1; step(); rst = 1'b0;
    weight = 32'h0004_0000; req = 8'h10;
    step();
    chk("t5_drop_first", {29'd0, o_grant_idx}, 32'd4);
    step();
    req = 8'h40;
    step();
    chk("t5_drop_next", {29'd0, o_grant_idx}, 32'd6);

    // T6: sole requester at the top index, then reset mid-burst
    rst = 1'b1; step(); rst = 1'b0;
    weight = {N{4'h1}}; req = 8'h80;
    repeat (4) begin
      step();
      chk("t6_sole_idx", {29'd0, o_grant_idx}, 32'd7);
    end
    weight = 32'h8111_1111;
    step(); step();
    rst = 1'b1;
    step();
    chk("t6_rst_grant", {24'd0, o_grant}, 32'd0);
    rst = 1'b0; req = 8'h81;
    step();
    chk("t6_after_rst", {29'd0, o_grant_idx}, 32'd0);

    // Randomized traffic
    rst = 1'b1; step(); rst = 1'b0;
    weight = $urandom;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(7) == 0) weight = $urandom;
      req   = N'($urandom) & N'($urandom | $urandom);
      last  = N'($urandom) & N'($urandom);
      ready = ($urandom_range(3) != 0);
      en    = ($urandom_range(7) != 0);
      rst   = ($urandom_range(63) == 0);
      step();
      chk("rnd_onehot", $countones(o_grant) <= 1 ? 32'd1 : 32'd0, 32'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
